// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus the writeback stage.
// Captures the memory stage outputs, selects the writeback value, drives the
// register-file write port and forwarding tap, and owns the architectural
// condition-code register that feeds the memory stage's branch comparator.
// Optional feature macro: MEM_WB_PERF_COUNT_EN (retired / bubble counters).

package lc3b_types;
    // Subset of the control word consumed by the writeback stage.
    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        logic [1:0] wb_sel;
    } lc3b_control_word;

    localparam logic [1:0] WB_RESULT = 2'b00;
    localparam logic [1:0] WB_WORD   = 2'b01;
    localparam logic [1:0] WB_BYTE   = 2'b10;
    localparam logic [1:0] WB_LINK   = 2'b11;
endpackage

module mem_wb_stage
    import lc3b_types::*;
#(
    parameter logic [2:0] CC_RESET = 3'b010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             mem_stall,
    input  logic             valid_in,
    input  lc3b_control_word cw_in,
    input  logic [15:0]      address_in,
    input  logic [15:0]      data_in,
    input  logic [15:0]      result_in,
    input  logic [15:0]      new_pc_in,
    input  logic [15:0]      ir_in,
    input  logic [2:0]       dr_in,
    output logic             regfile_load,
    output logic [2:0]       regfile_dest,
    output logic [15:0]      regfile_data,
    output logic [2:0]       cc,
    output logic             fwd_valid,
    output logic [2:0]       fwd_dr,
    output logic [15:0]      fwd_data,
    output logic [15:0]      wb_ir,
    output logic [31:0]      retire_count,
    output logic [31:0]      bubble_count
);

    logic             valid_q,   valid_d;
    lc3b_control_word cw_q,      cw_d;
    logic [15:0]      address_q, address_d;
    logic [15:0]      data_q,    data_d;
    logic [15:0]      result_q,  result_d;
    logic [15:0]      new_pc_q,  new_pc_d;
    logic [15:0]      ir_q,      ir_d;
    logic [2:0]       dr_q,      dr_d;
    logic [2:0]       cc_q,      cc_d;

    logic [15:0]      wb_data;
    logic [7:0]       byte_sel;
    logic             writes_regfile;

    // Only the byte-lane bit of the address matters here; the rest is kept
    // in the stage register for trace visibility.
    logic [14:0]      unused_addr_bits;
    assign unused_addr_bits = address_q[15:1];

    // Writeback select: ALU result, loaded word, zero-extended byte, link PC.
    always_comb begin
        byte_sel = address_q[0] ? data_q[15:8] : data_q[7:0];
        wb_data  = result_q;
        case (cw_q.wb_sel)
            WB_RESULT: wb_data = result_q;
            WB_WORD:   wb_data = data_q;
            WB_BYTE:   wb_data = {8'h00, byte_sel};
            WB_LINK:   wb_data = new_pc_q;
            default:   wb_data = result_q;
        endcase
    end

    assign writes_regfile = valid_q & cw_q.load_regfile;

    assign regfile_load = writes_regfile;
    assign regfile_dest = dr_q;
    assign regfile_data = wb_data;
    assign cc           = cc_q;
    assign fwd_valid    = writes_regfile;
    assign fwd_dr       = dr_q;
    assign fwd_data     = wb_data;
    assign wb_ir        = ir_q;

    // Next-state for the stage register: flush beats hold, hold beats stall.
    always_comb begin
        valid_d   = valid_q;
        cw_d      = cw_q;
        address_d = address_q;
        data_d    = data_q;
        result_d  = result_q;
        new_pc_d  = new_pc_q;
        ir_d      = ir_q;
        dr_d      = dr_q;
        if (flush) begin
            // Squash the entering instruction; payload loads but is never used.
            valid_d   = 1'b0;
            cw_d      = cw_in;
            address_d = address_in;
            data_d    = data_in;
            result_d  = result_in;
            new_pc_d  = new_pc_in;
            ir_d      = ir_in;
            dr_d      = dr_in;
        end else if (hold) begin
            valid_d   = valid_q;
        end else if (mem_stall) begin
            // Memory access still pending: present a bubble to writeback.
            valid_d   = 1'b0;
        end else begin
            valid_d   = valid_in;
            cw_d      = cw_in;
            address_d = address_in;
            data_d    = data_in;
            result_d  = result_in;
            new_pc_d  = new_pc_in;
            ir_d      = ir_in;
            dr_d      = dr_in;
        end
    end

    // Condition codes follow the value being written back (one-hot nzp).
    always_comb begin
        cc_d = cc_q;
        if (valid_q && cw_q.load_cc && !hold) begin
            if (wb_data == 16'h0000) begin
                cc_d = 3'b010;
            end else if (wb_data[15]) begin
                cc_d = 3'b100;
            end else begin
                cc_d = 3'b001;
            end
        end
    end

    // Stage register and CC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            cw_q      <= '0;
            address_q <= '0;
            data_q    <= '0;
            result_q  <= '0;
            new_pc_q  <= '0;
            ir_q      <= '0;
            dr_q      <= '0;
            cc_q      <= CC_RESET;
        end else begin
            valid_q   <= valid_d;
            cw_q      <= cw_d;
            address_q <= address_d;
            data_q    <= data_d;
            result_q  <= result_d;
            new_pc_q  <= new_pc_d;
            ir_q      <= ir_d;
            dr_q      <= dr_d;
            cc_q      <= cc_d;
        end
    end

`ifdef MEM_WB_PERF_COUNT_EN
    logic [31:0] retire_q, retire_d;
    logic [31:0] bubble_q, bubble_d;

    // Every non-hold cycle is either a retirement or a bubble.
    always_comb begin
        retire_d = retire_q;
        bubble_d = bubble_q;
        if (!hold) begin
            if (valid_q) begin
                retire_d = retire_q + 32'd1;
            end else begin
                bubble_d = bubble_q + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    assign retire_count = retire_q;
    assign bubble_count = bubble_q;
`else
    assign retire_count = 32'h0000_0000;
    assign bubble_count = 32'h0000_0000;
`endif

endmodule
